// File: rtl/truth_table_checker.sv
// Response-side checker for 4-input combinational benches: collects (vector, output) samples,
// builds the observed truth table, tracks coverage and checks against a golden table and Gray stepping.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED   = 16'hFA2C,
  parameter int          GRAY_CHECK = 1,
  parameter int          CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_vec,
  input  logic             in_s,
  output logic [15:0]      table_out,
  output logic [15:0]      covered,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             conflict,
  output logic             seq_err,
  output logic             done,
  output logic             pass,
  input  logic             ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      table_q, table_d;
  logic [15:0]      covered_q, covered_d;
  logic [CNT_W-1:0] mismatch_q, mismatch_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             conflict_q, conflict_d;
  logic             seq_err_q, seq_err_d;
  logic [3:0]       prev_vec_q, prev_vec_d;
  logic             have_prev_q, have_prev_d;
  logic             pass_q, pass_d;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    covered_d   = covered_q;
    mismatch_d  = mismatch_q;
    sample_d    = sample_q;
    conflict_d  = conflict_q;
    seq_err_d   = seq_err_q;
    prev_vec_d  = prev_vec_q;
    have_prev_d = have_prev_q;
    pass_d      = pass_q;

    // start always wins: it clears a run from any state and drops a coincident sample or ack
    if (start) begin
      state_d     = COLLECT;
      table_d     = '0;
      covered_d   = '0;
      mismatch_d  = '0;
      sample_d    = '0;
      conflict_d  = 1'b0;
      seq_err_d   = 1'b0;
      have_prev_d = 1'b0;
      pass_d      = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            table_d[in_vec]   = in_s;
            covered_d[in_vec] = 1'b1;
            if (sample_q != '1) begin
              sample_d = sample_q + 1'b1;
            end
            if ((in_s != EXPECTED[in_vec]) && (mismatch_q != '1)) begin
              mismatch_d = mismatch_q + 1'b1;
            end
            if (covered_q[in_vec] && (table_q[in_vec] != in_s)) begin
              conflict_d = 1'b1;
            end
            if ((GRAY_CHECK != 0) && have_prev_q && (popcount4(in_vec ^ prev_vec_q) != 3'd1)) begin
              seq_err_d = 1'b1;
            end
            prev_vec_d  = in_vec;
            have_prev_d = 1'b1;
            // verdict is taken from the post-update values so the final sample counts
            if (covered_d == 16'hFFFF) begin
              state_d = REPORT;
              pass_d  = (mismatch_d == '0) && !conflict_d && !seq_err_d;
            end
          end
        end
        REPORT: begin
          if (ack) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      table_q     <= '0;
      covered_q   <= '0;
      mismatch_q  <= '0;
      sample_q    <= '0;
      conflict_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      prev_vec_q  <= '0;
      have_prev_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      covered_q   <= covered_d;
      mismatch_q  <= mismatch_d;
      sample_q    <= sample_d;
      conflict_q  <= conflict_d;
      seq_err_q   <= seq_err_d;
      prev_vec_q  <= prev_vec_d;
      have_prev_q <= have_prev_d;
      pass_q      <= pass_d;
    end
  end

  assign in_ready     = (state_q == COLLECT);
  assign done         = (state_q == REPORT);
  assign pass         = pass_q;
  assign table_out    = table_q;
  assign covered      = covered_q;
  assign mismatch_cnt = mismatch_q;
  assign sample_cnt   = sample_q;
  assign conflict     = conflict_q;
  assign seq_err      = seq_err_q;

endmodule
